stats_pcie_if_mc: RTL and testbench

STATS_PCIE_IF_MC -- requirements
Module: stats_pcie_if_mc

---
 rtl/stats_pcie_if_mc_pkg.sv | 27 ++
 rtl/stats_pcie_tlp_dec.sv | 56 +++++
 rtl/stats_pcie_if_mc.sv | 168 ++++++++++++++++
 tb/tb_stats_pcie_if_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_pcie_if_mc_pkg.sv
// Shared definitions for the multi-channel PCIe TLP statistics collector:
// counter slot layout, TLP header field positions and flush FSM states.
package stats_pcie_if_mc_pkg;

    localparam int CNT_PER_CH     = 4;
    localparam int IDX_TLP        = 0;
    localparam int IDX_HDR_DW     = 1;
    localparam int IDX_PAYLOAD_DW = 2;
    localparam int IDX_EP         = 3;

    localparam int HDR_FMT_LSB = 125;
    localparam int HDR_FMT_W   = 3;
    localparam int HDR_EP_BIT  = 110;
    localparam int HDR_LEN_LSB = 96;
    localparam int HDR_LEN_W   = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Width holding the largest per-cycle channel sum (payload of 1024 DW per segment).
    function automatic int sum_width(input int seg_count);
        return $clog2(1024 * seg_count + 1);
    endfunction

endpackage

// File: rtl/stats_pcie_tlp_dec.sv
// Per-channel TLP header decode: sums TLP, header DW, payload DW and EP
// increments over all start-of-packet segments of one cycle.
module stats_pcie_tlp_dec
    import stats_pcie_if_mc_pkg::*;
#(
    parameter int SEG_COUNT     = 1,
    parameter int SEG_HDR_WIDTH = 128,
    parameter int SUM_W         = 11
) (
    input  logic [SEG_COUNT*SEG_HDR_WIDTH-1:0] hdr,
    input  logic [SEG_COUNT-1:0]               valid,
    input  logic [SEG_COUNT-1:0]               sop,
    output logic [SUM_W-1:0]                   tlp_inc,
    output logic [SUM_W-1:0]                   hdr_dw_inc,
    output logic [SUM_W-1:0]                   payload_dw_inc,
    output logic [SUM_W-1:0]                   ep_inc
);

    logic [HDR_FMT_W-1:0] fmt;
    logic [HDR_LEN_W-1:0] len;
    logic [10:0]          len_dw;
    logic                 ep;
    logic                 unused_hdr;

    // Only a few header bits matter; fold the rest so they are visibly consumed.
    assign unused_hdr = ^hdr;

    always_comb begin
        tlp_inc        = '0;
        hdr_dw_inc     = '0;
        payload_dw_inc = '0;
        ep_inc         = '0;
        fmt            = '0;
        len            = '0;
        len_dw         = '0;
        ep             = 1'b0;
        for (int s = 0; s < SEG_COUNT; s++) begin
            if (valid[s] && sop[s]) begin
                fmt    = hdr[s*SEG_HDR_WIDTH + HDR_FMT_LSB +: HDR_FMT_W];
                len    = hdr[s*SEG_HDR_WIDTH + HDR_LEN_LSB +: HDR_LEN_W];
                ep     = hdr[s*SEG_HDR_WIDTH + HDR_EP_BIT];
                // A zero length field encodes the maximum of 1024 DW.
                len_dw = (len == '0) ? 11'd1024 : {1'b0, len};
                tlp_inc    = tlp_inc + SUM_W'(1);
                hdr_dw_inc = hdr_dw_inc + (fmt[0] ? SUM_W'(4) : SUM_W'(3));
                if (fmt[1]) begin
                    payload_dw_inc = payload_dw_inc + SUM_W'(len_dw);
                end
                if (ep) begin
                    ep_inc = ep_inc + SUM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/stats_pcie_if_mc.sv
// Multi-channel PCIe TLP statistics: per-channel saturating accumulators,
// flushed as (id, increment) pairs over AXI-Stream by a scanning FSM.
module stats_pcie_if_mc
    import stats_pcie_if_mc_pkg::*;
#(
    parameter int CH_COUNT          = 4,
    parameter int TLP_SEG_COUNT     = 1,
    parameter int TLP_SEG_HDR_WIDTH = 128,
    parameter int STAT_INC_WIDTH    = 24,
    parameter int STAT_ID_WIDTH     = 5,
    parameter int UPDATE_PERIOD     = 1024
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [CH_COUNT*TLP_SEG_COUNT*TLP_SEG_HDR_WIDTH-1:0] tlp_hdr,
    input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                 tlp_valid,
    input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                 tlp_sop,
    input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                 tlp_eop,
    input  logic                                              enable,
    input  logic                                              update,
    output logic [STAT_INC_WIDTH-1:0]                         m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH-1:0]                          m_axis_stat_tid,
    output logic                                              m_axis_stat_tvalid,
    input  logic                                              m_axis_stat_tready
);

    localparam int N     = CH_COUNT * CNT_PER_CH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SUM_W = sum_width(TLP_SEG_COUNT);
    localparam int AW    = STAT_INC_WIDTH;
    localparam int XW    = ((SUM_W > AW) ? SUM_W : AW) + 1;
    localparam int SEG_W = TLP_SEG_COUNT * TLP_SEG_HDR_WIDTH;

    logic [SUM_W-1:0] inc_comb [N];
    logic [SUM_W-1:0] inc_reg  [N];
    logic [AW-1:0]    acc      [N];

    scan_state_t      state, state_next;
    logic [IDX_W-1:0] scan_idx, idx_next;
    logic             pending_flag, pending_next;
    logic             period_hit, flush_req, out_free, load;
    logic             unused_eop;

    assign unused_eop = ^tlp_eop;

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [SUM_W-1:0] b);
        logic [XW-1:0] s;
        s = XW'(a) + XW'(b);
        if (s > XW'({AW{1'b1}})) return {AW{1'b1}};
        return s[AW-1:0];
    endfunction

    for (genvar ch = 0; ch < CH_COUNT; ch++) begin : g_ch
        stats_pcie_tlp_dec #(
            .SEG_COUNT     (TLP_SEG_COUNT),
            .SEG_HDR_WIDTH (TLP_SEG_HDR_WIDTH),
            .SUM_W         (SUM_W)
        ) u_dec (
            .hdr            (tlp_hdr[ch*SEG_W +: SEG_W]),
            .valid          (tlp_valid[ch*TLP_SEG_COUNT +: TLP_SEG_COUNT]),
            .sop            (tlp_sop[ch*TLP_SEG_COUNT +: TLP_SEG_COUNT]),
            .tlp_inc        (inc_comb[ch*CNT_PER_CH + IDX_TLP]),
            .hdr_dw_inc     (inc_comb[ch*CNT_PER_CH + IDX_HDR_DW]),
            .payload_dw_inc (inc_comb[ch*CNT_PER_CH + IDX_PAYLOAD_DW]),
            .ep_inc         (inc_comb[ch*CNT_PER_CH + IDX_EP])
        );
    end

    if (UPDATE_PERIOD > 0) begin : g_period
        localparam int PER_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
        logic [PER_W-1:0] period_cnt;

        assign period_hit = (period_cnt == PER_W'(UPDATE_PERIOD - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                period_cnt <= '0;
            end else if (period_hit) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + PER_W'(1);
            end
        end
    end else begin : g_no_period
        assign period_hit = 1'b0;
    end

    assign flush_req = update | period_hit;

    // Stream handshake: an entry transfers on a cycle with tvalid && tready;
    // while tvalid is high and tready low, tdata/tid hold. The output register
    // is free when empty or draining this cycle, allowing one load per cycle.
    assign out_free = !m_axis_stat_tvalid || m_axis_stat_tready;

    always_comb begin
        state_next   = state;
        idx_next     = scan_idx;
        pending_next = pending_flag | flush_req;
        load         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending_flag) begin
                    state_next   = ST_SCAN;
                    idx_next     = '0;
                    pending_next = flush_req;
                end
            end
            ST_SCAN: begin
                if (out_free) begin
                    load = (acc[scan_idx] != '0);
                    if (scan_idx == IDX_W'(N - 1)) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = scan_idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            scan_idx     <= '0;
            pending_flag <= 1'b0;
        end else begin
            state        <= state_next;
            scan_idx     <= idx_next;
            pending_flag <= pending_next;
        end
    end

    // A flushed slot restarts from this cycle's increment so nothing is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                inc_reg[i] <= '0;
                acc[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                inc_reg[i] <= enable ? inc_comb[i] : '0;
                if (load && (scan_idx == IDX_W'(i))) begin
                    acc[i] <= sat_add('0, inc_reg[i]);
                end else begin
                    acc[i] <= sat_add(acc[i], inc_reg[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_stat_tvalid <= 1'b0;
            m_axis_stat_tdata  <= '0;
            m_axis_stat_tid    <= '0;
        end else if (load) begin
            m_axis_stat_tvalid <= 1'b1;
            m_axis_stat_tdata  <= acc[scan_idx];
            m_axis_stat_tid    <= STAT_ID_WIDTH'(scan_idx);
        end else if (m_axis_stat_tready) begin
            m_axis_stat_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stats_pcie_if_mc.sv
// Directed bench for stats_pcie_if_mc: three instances (default, 8-bit
// saturation, 16-cycle period) checked against an expected-transfer queue.
module tb_stats_pcie_if_mc;
    import stats_pcie_if_mc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] tlp_hdr;
    logic [3:0]   tlp_valid, tlp_sop, tlp_eop;
    logic         enable, update, tready;

    logic [23:0] a_tdata;  logic [4:0] a_tid;  logic a_tvalid;
    logic [7:0]  b_tdata;  logic [4:0] b_tid;  logic b_tvalid;
    logic [23:0] c_tdata;  logic [4:0] c_tid;  logic c_tvalid;

    logic [23:0] m_data;
    logic [4:0]  m_tid;
    logic        m_valid;

    int          sel, mode;
    logic [28:0] exp_q[$];
    int          tests, fails;
    int          tot[32];
    int          stall_checks;
    logic        prev_stall;
    logic [4:0]  prev_tid;
    logic [23:0] prev_data;

    always #5 clk = ~clk;

    stats_pcie_if_mc #(.UPDATE_PERIOD(0)) dut_a (
        .clk(clk), .rst(rst), .tlp_hdr(tlp_hdr), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop),
        .tlp_eop(tlp_eop), .enable(enable), .update(update), .m_axis_stat_tdata(a_tdata),
        .m_axis_stat_tid(a_tid), .m_axis_stat_tvalid(a_tvalid), .m_axis_stat_tready(tready));

    stats_pcie_if_mc #(.STAT_INC_WIDTH(8), .UPDATE_PERIOD(0)) dut_b (
        .clk(clk), .rst(rst), .tlp_hdr(tlp_hdr), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop),
        .tlp_eop(tlp_eop), .enable(enable), .update(update), .m_axis_stat_tdata(b_tdata),
        .m_axis_stat_tid(b_tid), .m_axis_stat_tvalid(b_tvalid), .m_axis_stat_tready(tready));

    stats_pcie_if_mc #(.CH_COUNT(1), .UPDATE_PERIOD(16)) dut_c (
        .clk(clk), .rst(rst), .tlp_hdr(tlp_hdr[127:0]), .tlp_valid(tlp_valid[0:0]),
        .tlp_sop(tlp_sop[0:0]), .tlp_eop(tlp_eop[0:0]), .enable(enable), .update(update),
        .m_axis_stat_tdata(c_tdata), .m_axis_stat_tid(c_tid), .m_axis_stat_tvalid(c_tvalid),
        .m_axis_stat_tready(tready));

    always_comb begin
        m_data  = a_tdata;
        m_tid   = a_tid;
        m_valid = a_tvalid;
        case (sel)
            1: begin m_data = {16'd0, b_tdata}; m_tid = b_tid; m_valid = b_tvalid; end
            2: begin m_data = c_tdata; m_tid = c_tid; m_valid = c_tvalid; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample/score the selected stream at negedge, return just after posedge.
    task automatic tick();
        logic [28:0] e;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_checks++;
                tests++;
                assert (m_valid === 1'b1 && m_tid === prev_tid && m_data === prev_data) else begin
                    fails++;
                    $error("FAIL hold_stable: observed v=%0b tid=%0d data=%0d, expected v=1 tid=%0d data=%0d",
                           m_valid, m_tid, m_data, prev_tid, prev_data);
                end
            end
            if (m_valid && tready) begin
                if (mode == 0) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        assert (exp_q.size() != 0) else begin
                            fails++;
                            $error("FAIL unexpected_xfer: observed tid=%0d data=%0d, expected no transfer",
                                   m_tid, m_data);
                        end
                    end else begin
                        e = exp_q.pop_front();
                        assert ({m_tid, m_data} === e) else begin
                            fails++;
                            $error("FAIL xfer: observed tid=%0d data=%0d, expected tid=%0d data=%0d",
                                   m_tid, m_data, e[28:24], e[23:0]);
                        end
                    end
                end else if (mode == 1) begin
                    tot[m_tid] += int'(m_data);
                end
            end
            prev_stall = m_valid && !tready;
            prev_tid   = m_tid;
            prev_data  = m_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_tlp(input int ch, input logic [2:0] fmt, input logic [9:0] len, input logic ep);
        logic [127:0] h;
        h = '0;
        h[127:125] = fmt;
        h[110]     = ep;
        h[105:96]  = len;
        tlp_hdr[ch*128 +: 128] = h;
        tlp_valid[ch] = 1'b1;
        tlp_sop[ch]   = 1'b1;
        tlp_eop[ch]   = 1'b1;
    endtask

    task automatic clear_tlp();
        tlp_hdr   = '0;
        tlp_valid = '0;
        tlp_sop   = '0;
        tlp_eop   = '0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        int          scans;
        scan_state_t prev_st;
        rst = 1'b1; enable = 1'b1; update = 1'b0; tready = 1'b1;
        sel = 0; mode = 2; tests = 0; fails = 0; stall_checks = 0; prev_stall = 1'b0;
        prev_tid = '0; prev_data = '0;
        for (int i = 0; i < 32; i++) tot[i] = 0;
        clear_tlp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("rst_tdata", {8'd0, a_tdata}, 32'd0);
        chk("rst_tid", {27'd0, a_tid}, 32'd0);
        rst = 1'b0;

        // 3DW MemRd on channel 0
        mode = 0; sel = 0;
        drive_tlp(0, 3'b000, 10'd16, 1'b0);
        exp_q.push_back({5'd0, 24'd1});
        exp_q.push_back({5'd1, 24'd3});
        tick();
        clear_tlp();
        pulse_update();
        run(30);
        chk("memrd_drained", exp_q.size(), 32'd0);

        // 4DW MemWr, length 0 (1024 DW), poisoned, on channel 2
        drive_tlp(2, 3'b011, 10'd0, 1'b1);
        exp_q.push_back({5'd8, 24'd1});
        exp_q.push_back({5'd9, 24'd4});
        exp_q.push_back({5'd10, 24'd1024});
        exp_q.push_back({5'd11, 24'd1});
        tick();
        clear_tlp();
        pulse_update();
        run(30);
        chk("memwr_drained", exp_q.size(), 32'd0);

        // Continuous TLPs on channel 1 with a 20-cycle stall during a scan
        mode = 1; stall_checks = 0;
        for (int c = 0; c < 40; c++) begin
            drive_tlp(1, 3'b010, 10'd2, 1'b0);
            tready = !(c >= 6 && c < 26);
            update = (c == 2);
            tick();
        end
        clear_tlp();
        update = 1'b0;
        tready = 1'b1;
        pulse_update();
        run(30);
        pulse_update();
        run(30);
        chk("stall_seen", {31'd0, stall_checks >= 10}, 32'd1);
        chk("sum_tlp", tot[4], 32'd40);
        chk("sum_hdr_dw", tot[5], 32'd120);
        chk("sum_payload_dw", tot[6], 32'd80);
        chk("sum_ep", tot[7], 32'd0);

        // Saturation with an 8-bit accumulator
        do_reset();
        sel = 1; mode = 0;
        drive_tlp(0, 3'b000, 10'd1, 1'b0);
        run(300);
        clear_tlp();
        exp_q.push_back({5'd0, 24'd255});
        exp_q.push_back({5'd1, 24'd255});
        pulse_update();
        run(30);
        chk("sat_drained", exp_q.size(), 32'd0);

        // Update coinciding with the period wrap yields a single scan
        do_reset();
        sel = 2; mode = 2;
        for (int i = 0; i < 20; i++) begin
            if (dut_c.g_period.period_cnt == 4'd15) break;
            tick();
        end
        chk("period_aligned", {28'd0, dut_c.g_period.period_cnt}, 32'd15);
        update = 1'b1;
        tick();
        update = 1'b0;
        scans = 0;
        prev_st = dut_c.state;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (dut_c.state == ST_SCAN && prev_st != ST_SCAN) scans++;
            if (i == 0) chk("merged_pending", {31'd0, dut_c.pending_flag}, 32'd0);
            prev_st = dut_c.state;
        end
        chk("single_scan", scans, 32'd1);

        // Reset mid-scan discards held and unsent counts
        do_reset();
        sel = 0; mode = 0; tready = 1'b0;
        drive_tlp(3, 3'b000, 10'd5, 1'b0);
        tick();
        clear_tlp();
        pulse_update();
        for (int i = 0; i < 30; i++) begin
            if (a_tvalid) break;
            tick();
        end
        chk("pre_rst_tvalid", {31'd0, a_tvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("async_rst_tdata", {8'd0, a_tdata}, 32'd0);
        chk("async_rst_tid", {27'd0, a_tid}, 32'd0);
        run(2);
        rst = 1'b0;
        tready = 1'b1;
        exp_q.delete();
        drive_tlp(0, 3'b001, 10'd7, 1'b0);
        exp_q.push_back({5'd0, 24'd1});
        exp_q.push_back({5'd1, 24'd4});
        tick();
        clear_tlp();
        pulse_update();
        run(30);
        chk("post_rst_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
